lcd_msg_sequencer: RTL and testbench

//   Parametrised successor of the LCD main controller. Drives the LCD write engine through a

---
 rtl/lcd_msg_sequencer.sv | 261 ++++++++++++++++++++++++++
 tb/tb_lcd_msg_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_msg_sequencer.sv
// -----------------------------------------------------------------------------
// lcd_msg_sequencer
//   Drives an LCD write engine through a four-phase req/finish handshake.
//   A frame consists of the fixed init command list (first frame only), then
//   for each display line a DDRAM address command followed by MSG_LEN
//   characters taken from an internal message buffer. With REFRESH=1 frames
//   repeat until a stop request is seen; otherwise one frame per start.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous reset, active high
//   start      : begin a sequence (sampled only while idle)
//   stop       : REFRESH=1 only, finish the current frame then go idle (sticky)
//   msg_we     : message buffer write enable
//   msg_waddr  : buffer write address, index = line*MSG_LEN + col
//   msg_wdata  : character code to store
//   lcd_finish : write-engine acknowledge level
//   lcd_req    : item request to the write engine
//   lcd_rs     : 0 = command byte, 1 = character byte
//   lcd_data   : command/character byte, stable while lcd_req is high
//   busy       : high from start acceptance until sequence end
//   done       : one-cycle pulse at sequence end
//   frame_cnt  : completed frames, wraps at 255
// -----------------------------------------------------------------------------
module lcd_msg_sequencer #(
  parameter int MSG_LEN = 16,
  parameter int LINES   = 2,
  parameter int ADDR_W  = 6,
  parameter int REFRESH = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              msg_we,
  input  logic [ADDR_W-1:0] msg_waddr,
  input  logic [7:0]        msg_wdata,
  input  logic              lcd_finish,
  output logic              lcd_req,
  output logic              lcd_rs,
  output logic [7:0]        lcd_data,
  output logic              busy,
  output logic              done,
  output logic [7:0]        frame_cnt
);

  localparam int               COL_W      = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int               DEPTH      = 1 << ADDR_W;
  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(MSG_LEN - 1);
  localparam logic [1:0]       LAST_LINE  = 2'(LINES - 1);
  localparam bit               REFRESH_EN = (REFRESH != 0);

  // Handshake phase of the current item.
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_LO, S_DONE} state_t;
  // Which kind of item is being sent.
  typedef enum logic [1:0] {K_INIT, K_ADDR, K_CHAR} kind_t;

  state_t             state_q, state_d;
  kind_t              kind_q,  kind_d;
  logic [1:0]         init_q,  init_d;
  logic [1:0]         line_q,  line_d;
  logic [COL_W-1:0]   col_q,   col_d;
  logic               stop_q,  stop_d;

  logic               req_d, rs_d, busy_d, done_d;
  logic [7:0]         data_d, frame_cnt_d;

  // Item to be loaded at the next REQ entry.
  kind_t              tgt_kind;
  logic [1:0]         tgt_init;
  logic [1:0]         tgt_line;
  logic [COL_W-1:0]   tgt_col;
  logic               frame_end;
  logic               tgt_rs;
  logic [7:0]         tgt_byte;
  logic [ADDR_W-1:0]  rd_addr;
  logic               load;

  logic [7:0]         msg_mem [DEPTH];

  function automatic logic [7:0] line_base(input logic [1:0] ln);
    case (ln)
      2'd0:    return 8'h00;
      2'd1:    return 8'h40;
      2'd2:    return 8'h14;
      default: return 8'h54;
    endcase
  endfunction

  // NOTE: the buffer has no reset; its contents are meaningless until the host
  // writes it, and keeping it out of reset lets it map onto plain RAM and
  // survive rst.
  always_ff @(posedge clk) begin
    if (msg_we) msg_mem[msg_waddr] <= msg_wdata;
  end

  // Successor of the current item. From idle the first item is init command 0;
  // after the last character of the last line the frame wraps to line 0's
  // address command, so refresh frames skip the init list.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    tgt_kind  = kind_q;
    tgt_init  = init_q;
    tgt_line  = line_q;
    tgt_col   = col_q;
    frame_end = 1'b0;
    if (state_q == S_IDLE) begin
      tgt_kind = K_INIT;
      tgt_init = 2'd0;
      tgt_line = 2'd0;
      tgt_col  = '0;
    end else begin
      case (kind_q)
        K_INIT: begin
          if (init_q == 2'd3) begin
            tgt_kind = K_ADDR;
            tgt_line = 2'd0;
          end else begin
            tgt_init = init_q + 2'd1;
          end
        end
        K_ADDR: begin
          tgt_kind = K_CHAR;
          tgt_col  = '0;
        end
        default: begin
          if (col_q != LAST_COL) begin
            tgt_col = col_q + 1'b1;
          end else if (line_q != LAST_LINE) begin
            tgt_kind = K_ADDR;
            tgt_line = line_q + 2'd1;
          end else begin
            frame_end = 1'b1;
            tgt_kind  = K_ADDR;
            tgt_line  = 2'd0;
          end
        end
      endcase
    end
  end

  // Byte for the target item. The buffer is read combinationally and captured
  // at REQ entry, so a write landing on that same edge is not seen until the
  // next time the character is sent.
  always_comb begin
    rd_addr  = ADDR_W'(int'(tgt_line) * MSG_LEN + int'(tgt_col));
    tgt_rs   = 1'b0;
    tgt_byte = 8'h00;
    case (tgt_kind)
      K_INIT: begin
        case (tgt_init)
          2'd0:    tgt_byte = 8'h38;
          2'd1:    tgt_byte = 8'h0C;
          2'd2:    tgt_byte = 8'h06;
          default: tgt_byte = 8'h01;
        endcase
      end
      K_ADDR:  tgt_byte = 8'h80 | line_base(tgt_line);
      default: begin
        tgt_rs   = 1'b1;
        tgt_byte = msg_mem[rd_addr];
      end
    endcase
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    init_d      = init_q;
    line_d      = line_q;
    col_d       = col_q;
    stop_d      = stop_q;
    req_d       = lcd_req;
    rs_d        = lcd_rs;
    data_d      = lcd_data;
    busy_d      = busy;
    done_d      = 1'b0;
    frame_cnt_d = frame_cnt;
    load        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          load   = 1'b1;
          busy_d = 1'b1;
        end
      end
      S_REQ: begin
        if (REFRESH_EN && stop) stop_d = 1'b1;
        if (lcd_finish) begin
          req_d   = 1'b0;
          state_d = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (REFRESH_EN && stop) stop_d = 1'b1;
        if (!lcd_finish) begin
          if (frame_end) frame_cnt_d = frame_cnt + 8'd1;
          if (frame_end && (!REFRESH_EN || stop_q || stop)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            stop_d  = 1'b0;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: begin
        // Done cycle: start is deliberately not looked at here.
        state_d = S_IDLE;
      end
    endcase

    if (load) begin
      state_d = S_REQ;
      req_d   = 1'b1;
      kind_d  = tgt_kind;
      init_d  = tgt_init;
      line_d  = tgt_line;
      col_d   = tgt_col;
      rs_d    = tgt_rs;
      data_d  = tgt_byte;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      kind_q    <= K_INIT;
      init_q    <= 2'd0;
      line_q    <= 2'd0;
      col_q     <= '0;
      stop_q    <= 1'b0;
      lcd_req   <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= 8'h00;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      init_q    <= init_d;
      line_q    <= line_d;
      col_q     <= col_d;
      stop_q    <= stop_d;
      lcd_req   <= req_d;
      lcd_rs    <= rs_d;
      lcd_data  <= data_d;
      busy      <= busy_d;
      done      <= done_d;
      frame_cnt <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_lcd_msg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lcd_msg_sequencer
//   Two sequencer instances (one-shot and continuous refresh) share the host
//   side; sel chooses which one the write-engine model and scoreboard talk to.
//   Expected items come from a frame table built at the top of the test and
//   are queued when a sequence is started, then popped on every REQ entry.
// -----------------------------------------------------------------------------
module tb_lcd_msg_sequencer;

  localparam int MSG_LEN = 16;
  localparam int LINES   = 2;
  localparam int ADDR_W  = 6;
  localparam int FRAME1  = 4 + LINES * (1 + MSG_LEN);
  localparam int FRAMER  = LINES * (1 + MSG_LEN);
  localparam int Z_IDX   = 4 + 1 + 5;  // table position of buffer address 5

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic sel = 1'b0;
  logic fin = 1'b0;
  logic tb_we = 1'b0;
  logic inj_we = 1'b0;
  logic [ADDR_W-1:0] tb_waddr = '0;
  logic [7:0] tb_wdata = 8'h00;

  logic msg_we;
  logic [ADDR_W-1:0] msg_waddr;
  logic [7:0] msg_wdata;
  logic start0, start1, fin0, fin1;
  logic req0, rs0, busy0, done0, req1, rs1, busy1, done1;
  logic [7:0] data0, fcnt0, data1, fcnt1;
  logic m_req, m_rs, m_busy, m_done;
  logic [7:0] m_data, m_fcnt;

  item_t      frame_tbl [FRAME1];
  logic [7:0] txt [LINES*MSG_LEN];
  item_t      exp_q [$];

  int n_vec = 0;
  int n_err = 0;
  int items_seen = 0;
  int done_seen = 0;
  int busy_fall = 0;
  int mode = 0;        // 0 = finish held low, 1 = ack after 2 cycles, 2 = free toggle
  bit wr_arm = 1'b0;
  int wr_at = 0;

  always #5 clk = ~clk;

  assign msg_we    = tb_we | inj_we;
  assign msg_waddr = inj_we ? ADDR_W'(5) : tb_waddr;
  assign msg_wdata = inj_we ? 8'h5A : tb_wdata;
  assign start0    = start & ~sel;
  assign start1    = start & sel;
  assign fin0      = sel ? 1'b0 : fin;
  assign fin1      = sel ? fin : 1'b0;
  assign m_req     = sel ? req1  : req0;
  assign m_rs      = sel ? rs1   : rs0;
  assign m_data    = sel ? data1 : data0;
  assign m_busy    = sel ? busy1 : busy0;
  assign m_done    = sel ? done1 : done0;
  assign m_fcnt    = sel ? fcnt1 : fcnt0;

  lcd_msg_sequencer #(.MSG_LEN(MSG_LEN), .LINES(LINES), .ADDR_W(ADDR_W), .REFRESH(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .stop(stop),
    .msg_we(msg_we), .msg_waddr(msg_waddr), .msg_wdata(msg_wdata),
    .lcd_finish(fin0), .lcd_req(req0), .lcd_rs(rs0), .lcd_data(data0),
    .busy(busy0), .done(done0), .frame_cnt(fcnt0)
  );

  lcd_msg_sequencer #(.MSG_LEN(MSG_LEN), .LINES(LINES), .ADDR_W(ADDR_W), .REFRESH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .stop(stop),
    .msg_we(msg_we), .msg_waddr(msg_waddr), .msg_wdata(msg_wdata),
    .lcd_finish(fin1), .lcd_req(req1), .lcd_rs(rs1), .lcd_data(data1),
    .busy(busy1), .done(done1), .frame_cnt(fcnt1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic build_table();
    string s;
    int k;
    for (int ln = 0; ln < LINES; ln++) begin
      s = (ln == 0) ? "HELLO WORLD 0123" : "LINE TWO ABCDEFG";
      for (int c = 0; c < MSG_LEN; c++) txt[ln*MSG_LEN + c] = s[c];
    end
    frame_tbl[0] = '{rs: 1'b0, data: 8'h38};
    frame_tbl[1] = '{rs: 1'b0, data: 8'h0C};
    frame_tbl[2] = '{rs: 1'b0, data: 8'h06};
    frame_tbl[3] = '{rs: 1'b0, data: 8'h01};
    k = 4;
    for (int ln = 0; ln < LINES; ln++) begin
      frame_tbl[k] = '{rs: 1'b0, data: (ln == 0) ? 8'h80 : 8'hC0};
      k++;
      for (int c = 0; c < MSG_LEN; c++) begin
        frame_tbl[k] = '{rs: 1'b1, data: txt[ln*MSG_LEN + c]};
        k++;
      end
    end
  endtask

  task automatic push_frame(input bit with_init, input bit z_patch);
    item_t it;
    for (int i = (with_init ? 0 : 4); i < FRAME1; i++) begin
      it = frame_tbl[i];
      if (z_patch && i == Z_IDX) it.data = 8'h5A;
      exp_q.push_back(it);
    end
  endtask

  task automatic load_buffer();
    for (int i = 0; i < LINES*MSG_LEN; i++) begin
      @(negedge clk);
      tb_we    = 1'b1;
      tb_waddr = ADDR_W'(i);
      tb_wdata = txt[i];
    end
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_items(input int target, input int max_cyc, input string name);
    int n = 0;
    while (items_seen < target && n < max_cyc) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (items_seen < target) check({name, "_timeout"}, 32'(items_seen), 32'(target));
  endtask

  task automatic wait_done(input int target, input int max_cyc, input string name);
    int n = 0;
    while (done_seen < target && n < max_cyc) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_seen < target) check({name, "_done_timeout"}, 32'(done_seen), 32'(target));
  endtask

  // Scoreboard on REQ entry plus the write-engine model, both at the falling edge.
  task automatic monitor_loop();
    item_t exp;
    logic prev_req = 1'b0;
    logic prev_busy = 1'b0;
    int ack_cnt = 0;
    int tog_cnt = 0;
    forever begin
      @(negedge clk);
      inj_we = 1'b0;
      if (rst) begin
        prev_req = 1'b0; prev_busy = 1'b0; fin = 1'b0; ack_cnt = 0; tog_cnt = 0;
      end else begin
        if (m_req && !prev_req) begin
          items_seen++;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL extra_item: got rs=%0b data=0x%02h, expected no item", m_rs, m_data);
          end else begin
            exp = exp_q.pop_front();
            check($sformatf("item%0d", items_seen), 32'({m_rs, m_data}), 32'(exp));
          end
        end
        if (m_done) done_seen++;
        if (prev_busy && !m_busy) busy_fall++;
        prev_req  = m_req;
        prev_busy = m_busy;
        case (mode)
          1: begin
            if (m_req) begin
              if (!fin) begin
                ack_cnt++;
                if (ack_cnt >= 2) fin = 1'b1;
              end
            end else if (fin) begin
              fin = 1'b0;
              ack_cnt = 0;
              // The next rising edge is the REQ entry of item wr_at.
              if (wr_arm && items_seen == wr_at) begin
                inj_we = 1'b1;
                wr_arm = 1'b0;
              end
            end
          end
          2: begin
            tog_cnt++;
            if (tog_cnt == 7) begin
              fin = ~fin;
              tog_cnt = 0;
            end
          end
          default: begin
            fin = 1'b0; ack_cnt = 0; tog_cnt = 0;
          end
        endcase
      end
    end
  endtask

  initial begin
    int b, d, bf;
    build_table();
    fork
      monitor_loop();
    join_none

    // Reset state of both instances
    #2;
    check("rst_req0", 32'(req0), 0);   check("rst_rs0", 32'(rs0), 0);
    check("rst_data0", 32'(data0), 0); check("rst_busy0", 32'(busy0), 0);
    check("rst_done0", 32'(done0), 0); check("rst_fcnt0", 32'(fcnt0), 0);
    check("rst_req1", 32'(req1), 0);   check("rst_fcnt1", 32'(fcnt1), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    load_buffer();

    // One-shot frame, ack 2 cycles after req
    mode = 1; sel = 1'b0;
    push_frame(1'b1, 1'b0);
    b = items_seen; d = done_seen; bf = busy_fall;
    pulse_start();
    #1;
    check("t1_lat_busy", 32'(m_busy), 1);  check("t1_lat_req", 32'(m_req), 1);
    check("t1_lat_rs", 32'(m_rs), 0);      check("t1_lat_data", 32'(m_data), 32'h38);
    wait_done(d + 1, 1000, "t1");
    check("t1_done", 32'(m_done), 1);      check("t1_busy_end", 32'(m_busy), 0);
    check("t1_fcnt", 32'(m_fcnt), 1);      check("t1_items", 32'(items_seen - b), 32'(FRAME1));
    check("t1_qempty", 32'(exp_q.size()), 0);
    check("t1_busy_falls", 32'(busy_fall - bf), 1);
    @(negedge clk);
    #1;
    check("t1_done_1cyc", 32'(m_done), 0);

    // Free-running 7/7 finish toggle
    mode = 2;
    push_frame(1'b1, 1'b0);
    b = items_seen; d = done_seen;
    pulse_start();
    wait_done(d + 1, 3000, "t2");
    check("t2_fcnt", 32'(m_fcnt), 2);      check("t2_items", 32'(items_seen - b), 32'(FRAME1));
    check("t2_qempty", 32'(exp_q.size()), 0);
    mode = 0;
    repeat (3) @(negedge clk);

    // start while busy and on the done cycle is ignored
    mode = 1;
    push_frame(1'b1, 1'b0);
    b = items_seen; d = done_seen; bf = busy_fall;
    pulse_start();
    wait_items(b + 10, 500, "t3_item10");
    pulse_start();
    wait_done(d + 1, 1000, "t3");
    pulse_start();
    repeat (20) @(negedge clk);
    #1;
    check("t3_items", 32'(items_seen - b), 32'(FRAME1));
    check("t3_dones", 32'(done_seen - d), 1);
    check("t3_busy_falls", 32'(busy_fall - bf), 1);
    check("t3_idle_busy", 32'(m_busy), 0);
    check("t3_fcnt", 32'(m_fcnt), 3);

    // Refresh: stop in idle not latched, buffer write at REQ entry, stop in frame 3
    sel = 1'b1;
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    push_frame(1'b1, 1'b0);
    push_frame(1'b0, 1'b1);
    push_frame(1'b0, 1'b1);
    b = items_seen; d = done_seen;
    wr_at = b + Z_IDX; wr_arm = 1'b1;
    pulse_start();
    wait_items(b + FRAME1 + 1, 1000, "t4_f2");
    check("t4_fcnt_f2", 32'(m_fcnt), 1);
    check("t4_busy_f2", 32'(m_busy), 1);
    wait_items(b + FRAME1 + FRAMER + 1, 1000, "t4_f3");
    check("t4_fcnt_f3", 32'(m_fcnt), 2);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done(d + 1, 1000, "t4");
    check("t4_fcnt_end", 32'(m_fcnt), 3);
    check("t4_items", 32'(items_seen - b), 32'(FRAME1 + 2*FRAMER));
    check("t4_qempty", 32'(exp_q.size()), 0);
    repeat (5) @(negedge clk);
    #1;
    check("t4_dones", 32'(done_seen - d), 1);
    check("t4_idle_busy", 32'(m_busy), 0);

    // Reset mid-CHAR of line 1, buffer (with 'Z') retained, restart from INIT
    sel = 1'b0;
    push_frame(1'b1, 1'b1);
    b = items_seen;
    pulse_start();
    wait_items(b + 30, 500, "t6_mid");
    #2;
    rst = 1'b1;
    #1;
    check("t6_req", 32'(req0), 0);   check("t6_rs", 32'(rs0), 0);
    check("t6_data", 32'(data0), 0); check("t6_busy", 32'(busy0), 0);
    check("t6_fcnt", 32'(fcnt0), 0); check("t6_done", 32'(done0), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    push_frame(1'b1, 1'b1);
    b = items_seen; d = done_seen;
    pulse_start();
    #1;
    check("t6_restart_data", 32'(m_data), 32'h38);
    wait_done(d + 1, 1000, "t6");
    check("t6_items", 32'(items_seen - b), 32'(FRAME1));
    check("t6_fcnt_end", 32'(m_fcnt), 1);
    check("t6_qempty", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
